// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in / serial-out transmitter. Takes a DATA_W-bit word
//               over a valid/ready handshake and sends it one bit per clk on
//               ser_out, with frame_start / frame_end strobes. Back-to-back
//               words stream with no idle cycle between frames.
// Config      : `define PISO_PARITY_EN appends one even-parity bit (XOR of the
//               data bits) after the data; frame_end then marks the parity bit.
// Parameters  : DATA_W    - word width, 2..32
//               MSB_FIRST - 1: bit DATA_W-1 first, 0: bit 0 first
// Ports       : clk, rst_n (async, active-low)
//               in_valid, in_data[DATA_W-1:0], in_ready (combinational)
//               ser_out, ser_valid, frame_start, frame_end, busy (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               r_state, w_state_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;
  logic [FRAME_LEN-1:0] r_sreg, w_sreg_d;
  logic                 w_ser_out_d, w_ser_valid_d, w_frame_start_d, w_frame_end_d;

  logic [DATA_W-1:0]    w_ordered;
  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_last;
  logic                 w_xfer;

  // Put the word in transmit order so the shifter always sends its MSB first.
  if (MSB_FIRST) begin : g_msb_first
    assign w_ordered = in_data;
  end else begin : g_lsb_first
    for (genvar i = 0; i < DATA_W; i++) begin : g_rev
      assign w_ordered[i] = in_data[DATA_W-1-i];
    end
  end

`ifdef PISO_PARITY_EN
  assign w_frame = {w_ordered, ^in_data};
`else
  assign w_frame = w_ordered;
`endif

  // Last bit of the current frame is on the wire this cycle.
  assign w_last = (r_state == SHIFT) && (r_cnt == '0);
  assign w_xfer = in_valid && in_ready;

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_sreg_d        = r_sreg;
    w_ser_out_d     = 1'b0;
    w_ser_valid_d   = 1'b0;
    w_frame_start_d = 1'b0;
    w_frame_end_d   = 1'b0;
    in_ready        = rst_n && ((r_state == IDLE) || w_last);

    if (in_valid && in_ready) begin
      // Load: first bit goes straight to the output register, the rest
      // stays in the shifter aligned to its top bit.
      w_state_d       = SHIFT;
      w_ser_out_d     = w_frame[FRAME_LEN-1];
      w_sreg_d        = {w_frame[FRAME_LEN-2:0], 1'b0};
      w_cnt_d         = CNT_LOAD;
      w_ser_valid_d   = 1'b1;
      w_frame_start_d = 1'b1;
    end else if ((r_state == SHIFT) && (r_cnt != '0)) begin
      w_ser_out_d     = r_sreg[FRAME_LEN-1];
      w_sreg_d        = {r_sreg[FRAME_LEN-2:0], 1'b0};
      w_cnt_d         = r_cnt - 1'b1;
      w_ser_valid_d   = 1'b1;
      // Counter tracks the bit on the wire, so end is flagged as it hits 0.
      w_frame_end_d   = (r_cnt == CNT_W'(1));
    end else begin
      w_state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sreg      <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_sreg      <= w_sreg_d;
      ser_out     <= w_ser_out_d;
      ser_valid   <= w_ser_valid_d;
      frame_start <= w_frame_start_d;
      frame_end   <= w_frame_end_d;
    end
  end

  assign busy = ser_valid;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_tx
// Description : Directed self-checking bench for piso_shift_tx (DATA_W=4).
//               Instance a: MSB_FIRST=1, instance b: MSB_FIRST=0.
//               Expected frames follow PISO_PARITY_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

`ifdef PISO_PARITY_EN
  localparam int FL = 5;
  localparam logic [5:0] E_1011_M = 6'b010111;
  localparam logic [5:0] E_1011_L = 6'b011011;
  localparam logic [5:0] E_1100   = 6'b011000;
  localparam logic [5:0] E_0011   = 6'b000110;
  localparam logic [5:0] E_1111   = 6'b011110;
  localparam logic [5:0] E_0110   = 6'b001100;
`else
  localparam int FL = 4;
  localparam logic [5:0] E_1011_M = 6'b001011;
  localparam logic [5:0] E_1011_L = 6'b001101;
  localparam logic [5:0] E_1100   = 6'b001100;
  localparam logic [5:0] E_0011   = 6'b000011;
  localparam logic [5:0] E_1111   = 6'b001111;
  localparam logic [5:0] E_0110   = 6'b000110;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic [3:0] a_data, b_data;
  logic       a_ready, a_ser, a_sv, a_fs, a_fe, a_busy;
  logic       b_ready, b_ser, b_sv, b_fs, b_fe, b_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.DATA_W(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .ser_out(a_ser), .ser_valid(a_sv),
    .frame_start(a_fs), .frame_end(a_fe), .busy(a_busy)
  );

  piso_shift_tx #(.DATA_W(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .ser_out(b_ser), .ser_valid(b_sv),
    .frame_start(b_fs), .frame_end(b_fe), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the transfer edge; walks the whole frame.
  task automatic run_frame(input bit sel, input logic [5:0] e, input string tag);
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("%s_ser%0d", tag, i),   sel ? b_ser   : a_ser,   e[FL-1-i]);
      chk($sformatf("%s_sv%0d", tag, i),    sel ? b_sv    : a_sv,    1);
      chk($sformatf("%s_busy%0d", tag, i),  sel ? b_busy  : a_busy,  1);
      chk($sformatf("%s_fs%0d", tag, i),    sel ? b_fs    : a_fs,    (i == 0)    ? 1 : 0);
      chk($sformatf("%s_fe%0d", tag, i),    sel ? b_fe    : a_fe,    (i == FL-1) ? 1 : 0);
      chk($sformatf("%s_rdy%0d", tag, i),   sel ? b_ready : a_ready, (i == FL-1) ? 1 : 0);
      tick();
    end
  endtask

  task automatic chk_idle(input bit sel, input string tag);
    chk({tag, "_ser"},  sel ? b_ser   : a_ser,   0);
    chk({tag, "_sv"},   sel ? b_sv    : a_sv,    0);
    chk({tag, "_busy"}, sel ? b_busy  : a_busy,  0);
    chk({tag, "_fs"},   sel ? b_fs    : a_fs,    0);
    chk({tag, "_fe"},   sel ? b_fe    : a_fe,    0);
    chk({tag, "_rdy"},  sel ? b_ready : a_ready, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b0; a_data = 4'h0;
    b_valid = 1'b0; b_data = 4'h0;

    // Reset state
    #12;
    chk("rst_ser",  a_ser, 0);
    chk("rst_sv",   a_sv, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_fs",   a_fs, 0);
    chk("rst_fe",   a_fe, 0);
    chk("rst_rdy_a", a_ready, 0);
    chk("rst_rdy_b", b_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk_idle(1'b0, "post_rst_a");
    chk_idle(1'b1, "post_rst_b");

    // Single word MSB-first; data goes X once in_valid drops
    a_valid = 1'b1; a_data = 4'b1011;
    tick();
    a_valid = 1'b0; a_data = 4'bxxxx;
    run_frame(1'b0, E_1011_M, "single");
    chk_idle(1'b0, "single_end");
    tick();
    chk_idle(1'b0, "single_idle_x");

    // LSB-first variant
    b_valid = 1'b1; b_data = 4'b1011;
    tick();
    b_valid = 1'b0; b_data = 4'h0;
    run_frame(1'b1, E_1011_L, "lsb");
    chk_idle(1'b1, "lsb_end");

    // Back-to-back: second word held valid, taken on the last-bit edge
    a_valid = 1'b1; a_data = 4'b1100;
    tick();
    a_data = 4'b0011;
    run_frame(1'b0, E_1100, "b2b1");
    a_valid = 1'b0;
    run_frame(1'b0, E_0011, "b2b2");
    chk_idle(1'b0, "b2b_end");

    // Backpressure: 4'hF offered during the frame, must wait for last bit
    a_valid = 1'b1; a_data = 4'b1011;
    tick();
    a_data = 4'hF;
    run_frame(1'b0, E_1011_M, "bp1");
    a_valid = 1'b0;
    run_frame(1'b0, E_1111, "bp2");
    chk_idle(1'b0, "bp_end");

    // Word with even bit count (parity bit 0 when enabled)
    a_valid = 1'b1; a_data = 4'b0110;
    tick();
    a_valid = 1'b0;
    run_frame(1'b0, E_0110, "w0110");
    chk_idle(1'b0, "w0110_end");

    // Reset mid-frame after bit 2 of 4'b1011
    a_valid = 1'b1; a_data = 4'b1011;
    tick();
    a_valid = 1'b0;
    tick();
    chk("mid_bit2", a_ser, E_1011_M[FL-2]);
    chk("mid_bit2_sv", a_sv, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ser",  a_ser, 0);
    chk("mid_rst_sv",   a_sv, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_fs",   a_fs, 0);
    chk("mid_rst_fe",   a_fe, 0);
    chk("mid_rst_rdy",  a_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk_idle(1'b0, "mid_rel");
    tick();
    chk_idle(1'b0, "mid_rel_hold");

    // Clean frame after the aborted one
    a_valid = 1'b1; a_data = 4'b0011;
    tick();
    a_valid = 1'b0;
    run_frame(1'b0, E_0011, "after_rst");
    chk_idle(1'b0, "after_rst_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
